// File: rtl/alu_share_arbiter.sv
// Round-robin front end that time-shares one external MIPS ALU among NREQ requesters.
// 64-bit ADD runs as two chained 32-bit passes, with the carry passed through alu_cin.
module alu_share_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*6-1:0]    req_op,
    input  logic [NREQ-1:0]      req_wide,
    input  logic [NREQ*64-1:0]   req_a,
    input  logic [NREQ*64-1:0]   req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [63:0]          rsp_res,
    output logic                 rsp_zero,
    output logic                 rsp_ovf,
    output logic                 rsp_cout,
    output logic                 rsp_err,
    output logic [3:0]           alu_ctl,
    output logic [31:0]          alu_a,
    output logic [31:0]          alu_b,
    output logic                 alu_cin,
    input  logic [31:0]          alu_res,
    input  logic                 alu_zero,
    input  logic                 alu_ovf,
    input  logic                 alu_cout
);

    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2A;
    localparam logic [5:0] F_NOOP = 6'h2C;

    localparam logic [3:0] C_AND  = 4'h0;
    localparam logic [3:0] C_OR   = 4'h1;
    localparam logic [3:0] C_ADD  = 4'h2;
    localparam logic [3:0] C_XOR  = 4'h3;
    localparam logic [3:0] C_SUB  = 4'h6;
    localparam logic [3:0] C_SLT  = 4'h7;
    localparam logic [3:0] C_NOR  = 4'hC;
    localparam logic [3:0] C_NOOP = 4'hF;

    typedef enum logic [1:0] {S_IDLE, S_EXEC_LO, S_EXEC_HI, S_RESP} state_t;

    state_t          r_state;
    logic [IDW-1:0]  r_rr_ptr;
    logic            r_wide;
    logic [31:0]     r_a_hi;
    logic [31:0]     r_b_hi;
    logic [31:0]     r_lo_res;
    logic            r_lo_zero;
    logic            r_rsp_valid;
    logic [IDW-1:0]  r_rsp_id;
    logic [63:0]     r_rsp_res;
    logic            r_rsp_zero;
    logic            r_rsp_ovf;
    logic            r_rsp_cout;
    logic            r_rsp_err;
    logic [3:0]      r_alu_ctl;
    logic [31:0]     r_alu_a;
    logic [31:0]     r_alu_b;
    logic            r_alu_cin;

    logic            w_gnt_any;
    logic [IDW-1:0]  w_gnt_id;
    logic [NREQ-1:0] w_gnt_oh;
    logic [5:0]      w_sel_op;
    logic            w_sel_wide;
    logic [63:0]     w_sel_a;
    logic [63:0]     w_sel_b;
    logic [3:0]      w_dec_ctl;
    logic            w_dec_legal;
    logic            w_bad;

    // Scan from the highest distance down so the requester nearest rr_ptr wins.
    always_comb begin : grant_scan
        logic [IDW:0] w_idx;
        w_gnt_any = 1'b0;
        w_gnt_id  = '0;
        w_idx     = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_idx = {1'b0, r_rr_ptr} + (IDW+1)'(k);
            if (w_idx >= (IDW+1)'(NREQ))
                w_idx = w_idx - (IDW+1)'(NREQ);
            if (req_valid[w_idx[IDW-1:0]]) begin
                w_gnt_any = 1'b1;
                w_gnt_id  = w_idx[IDW-1:0];
            end
        end
    end

    always_comb begin
        w_gnt_oh = '0;
        if (rst_n && (r_state == S_IDLE) && w_gnt_any)
            w_gnt_oh[w_gnt_id] = 1'b1;
    end

    always_comb begin
        w_sel_op   = '0;
        w_sel_wide = 1'b0;
        w_sel_a    = '0;
        w_sel_b    = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt_id == IDW'(i)) begin
                w_sel_op   = req_op[6*i +: 6];
                w_sel_wide = req_wide[i];
                w_sel_a    = req_a[64*i +: 64];
                w_sel_b    = req_b[64*i +: 64];
            end
        end
    end

    always_comb begin
        w_dec_ctl   = C_NOOP;
        w_dec_legal = 1'b1;
        case (w_sel_op)
            F_ADD:   w_dec_ctl = C_ADD;
            F_SUB:   w_dec_ctl = C_SUB;
            F_AND:   w_dec_ctl = C_AND;
            F_OR:    w_dec_ctl = C_OR;
            F_XOR:   w_dec_ctl = C_XOR;
            F_NOR:   w_dec_ctl = C_NOR;
            F_SLT:   w_dec_ctl = C_SLT;
            F_NOOP:  w_dec_ctl = C_NOOP;
            default: w_dec_legal = 1'b0;
        endcase
    end

    assign w_bad = !w_dec_legal || (w_sel_wide && (w_sel_op != F_ADD));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= '0;
            r_wide      <= 1'b0;
            r_a_hi      <= '0;
            r_b_hi      <= '0;
            r_lo_res    <= '0;
            r_lo_zero   <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_res   <= '0;
            r_rsp_zero  <= 1'b0;
            r_rsp_ovf   <= 1'b0;
            r_rsp_cout  <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_alu_ctl   <= C_NOOP;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_cin   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_gnt_any) begin
                        r_rsp_id <= w_gnt_id;
                        r_rr_ptr <= (w_gnt_id == IDW'(NREQ - 1)) ? '0 : w_gnt_id + 1'b1;
                        r_wide   <= w_sel_wide;
                        r_a_hi   <= w_sel_a[63:32];
                        r_b_hi   <= w_sel_b[63:32];
                        if (w_bad || (w_dec_ctl == C_NOOP)) begin
                            // Error and NOOP skip the ALU and answer with a fixed result.
                            r_state     <= S_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_res   <= '0;
                            r_rsp_zero  <= 1'b1;
                            r_rsp_ovf   <= 1'b0;
                            r_rsp_cout  <= 1'b0;
                            r_rsp_err   <= w_bad;
                        end else begin
                            r_state   <= S_EXEC_LO;
                            r_alu_ctl <= w_dec_ctl;
                            r_alu_a   <= w_sel_a[31:0];
                            r_alu_b   <= w_sel_b[31:0];
                            r_alu_cin <= 1'b0;
                        end
                    end
                end
                S_EXEC_LO: begin
                    if (r_wide) begin
                        r_state   <= S_EXEC_HI;
                        r_lo_res  <= alu_res;
                        r_lo_zero <= alu_zero;
                        r_alu_ctl <= C_ADD;
                        r_alu_a   <= r_a_hi;
                        r_alu_b   <= r_b_hi;
                        r_alu_cin <= alu_cout;
                    end else begin
                        r_state     <= S_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_res   <= {32'd0, alu_res};
                        r_rsp_zero  <= alu_zero;
                        r_rsp_ovf   <= alu_ovf;
                        r_rsp_cout  <= alu_cout;
                        r_rsp_err   <= 1'b0;
                        r_alu_ctl   <= C_NOOP;
                        r_alu_cin   <= 1'b0;
                    end
                end
                S_EXEC_HI: begin
                    r_state     <= S_RESP;
                    r_rsp_valid <= 1'b1;
                    r_rsp_res   <= {alu_res, r_lo_res};
                    r_rsp_zero  <= r_lo_zero & alu_zero;
                    r_rsp_ovf   <= alu_ovf;
                    r_rsp_cout  <= alu_cout;
                    r_rsp_err   <= 1'b0;
                    r_alu_ctl   <= C_NOOP;
                    r_alu_cin   <= 1'b0;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_state     <= S_IDLE;
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready = w_gnt_oh;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_res   = r_rsp_res;
    assign rsp_zero  = r_rsp_zero;
    assign rsp_ovf   = r_rsp_ovf;
    assign rsp_cout  = r_rsp_cout;
    assign rsp_err   = r_rsp_err;
    assign alu_ctl   = r_alu_ctl;
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_cin   = r_alu_cin;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: stub MIPS ALU, spec-level transaction model checked every
// cycle, plus directed vectors with literal expectations.
module tb_alu_share_arbiter;
    localparam int NREQ = 2;
    localparam int IDW  = 1;
    localparam logic [3:0] NOOP = 4'hF;

    logic                clk, rst_n;
    logic [NREQ-1:0]     req_valid, req_ready, req_wide;
    logic [NREQ*6-1:0]   req_op;
    logic [NREQ*64-1:0]  req_a, req_b;
    logic                rsp_valid, rsp_ready, rsp_zero, rsp_ovf, rsp_cout, rsp_err;
    logic [IDW-1:0]      rsp_id;
    logic [63:0]         rsp_res;
    logic [3:0]          alu_ctl;
    logic [31:0]         alu_a, alu_b, alu_res;
    logic                alu_cin, alu_zero, alu_ovf, alu_cout;
    logic [32:0]         alu_s;

    alu_share_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_wide(req_wide),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_res(rsp_res),
        .rsp_zero(rsp_zero), .rsp_ovf(rsp_ovf), .rsp_cout(rsp_cout), .rsp_err(rsp_err),
        .alu_ctl(alu_ctl), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
        .alu_res(alu_res), .alu_zero(alu_zero), .alu_ovf(alu_ovf), .alu_cout(alu_cout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Stub of the shared MIPS ALU (SUB carry = no-borrow).
    always_comb begin
        alu_s    = '0;
        alu_res  = '0;
        alu_ovf  = 1'b0;
        alu_cout = 1'b0;
        case (alu_ctl)
            4'h0: alu_res = alu_a & alu_b;
            4'h1: alu_res = alu_a | alu_b;
            4'h3: alu_res = alu_a ^ alu_b;
            4'hC: alu_res = ~(alu_a | alu_b);
            4'h7: alu_res = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
            4'h2: begin
                alu_s    = {1'b0, alu_a} + {1'b0, alu_b} + {32'd0, alu_cin};
                alu_res  = alu_s[31:0];
                alu_cout = alu_s[32];
                alu_ovf  = (alu_a[31] == alu_b[31]) && (alu_s[31] != alu_a[31]);
            end
            4'h6: begin
                alu_s    = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
                alu_res  = alu_s[31:0];
                alu_cout = alu_s[32];
                alu_ovf  = (alu_a[31] != alu_b[31]) && (alu_s[31] != alu_a[31]);
            end
            default: alu_res = '0;
        endcase
        alu_zero = (alu_res == 32'd0);
    end

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    function automatic logic [3:0] ctl_of(input logic [5:0] op);
        case (op)
            6'h20: return 4'h2;
            6'h22: return 4'h6;
            6'h24: return 4'h0;
            6'h25: return 4'h1;
            6'h26: return 4'h3;
            6'h27: return 4'hC;
            6'h2A: return 4'h7;
            default: return NOOP;
        endcase
    endfunction

    // Returns {err, cout, ovf, zero, res[63:0]} from the arithmetic meaning of the request.
    function automatic logic [67:0] model_rsp(input logic [5:0] op, input logic w,
                                              input logic [63:0] a, input logic [63:0] b);
        logic [64:0] s;
        logic [31:0] x, y, r;
        logic e, c, o;
        e = 1'b0; c = 1'b0; o = 1'b0; r = '0;
        x = a[31:0]; y = b[31:0];
        if (w) begin
            if (op != 6'h20) return {4'b1001, 64'd0};
            s = {1'b0, a} + {1'b0, b};
            return {1'b0, s[64], (a[63] == b[63]) && (s[63] != a[63]), s[63:0] == 64'd0, s[63:0]};
        end
        case (op)
            6'h20: begin
                {c, r} = {1'b0, x} + {1'b0, y};
                o = (x[31] == y[31]) && (r[31] != x[31]);
            end
            6'h22: begin
                r = x - y;
                c = (x >= y);
                o = (x[31] != y[31]) && (r[31] != x[31]);
            end
            6'h24: r = x & y;
            6'h25: r = x | y;
            6'h26: r = x ^ y;
            6'h27: r = ~(x | y);
            6'h2A: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            6'h2C: r = '0;
            default: e = 1'b1;
        endcase
        return {e, c, o, r == 32'd0, 32'd0, r};
    endfunction

    // Model state and observation log
    int          acc_cnt = 0, rsp_cnt = 0;
    int          gnt_log [0:63];
    int          m_rr = 0, m_g, m_d, acc_cyc, cyc = 0;
    logic        busy = 1'b0, seen;
    logic [NREQ-1:0] m_ready;
    logic [5:0]  t_op;
    logic        t_wide;
    logic [63:0] t_a, t_b;
    int          t_id, t_lat;
    logic [67:0] t_exp;
    logic [63:0] last_res;
    logic [3:0]  last_flags;
    int          last_id, last_lat, last_hold;
    logic        last_hi_cin;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                busy = 1'b0;
                m_rr = 0;
                chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
                chk("rst_req_ready", 64'(req_ready), 64'd0);
                chk("rst_alu_ctl", 64'(alu_ctl), 64'(NOOP));
                chk("rst_alu_ab", {alu_a, alu_b}, 64'd0);
                chk("rst_alu_cin", 64'(alu_cin), 64'd0);
                chk("rst_rsp_fields", rsp_res | 64'({rsp_id, rsp_zero, rsp_ovf, rsp_cout, rsp_err}), 64'd0);
            end else if (!busy) begin
                m_g = -1;
                for (int k = 0; k < NREQ; k++)
                    if (m_g < 0 && req_valid[(m_rr + k) % NREQ]) m_g = (m_rr + k) % NREQ;
                m_ready = '0;
                if (m_g >= 0) m_ready[m_g] = 1'b1;
                chk("idle_req_ready", 64'(req_ready), 64'(m_ready));
                chk("idle_rsp_valid", 64'(rsp_valid), 64'd0);
                chk("idle_alu_ctl", 64'(alu_ctl), 64'(NOOP));
                if (m_g >= 0) begin
                    busy    = 1'b1;
                    seen    = 1'b0;
                    acc_cyc = cyc;
                    t_id    = m_g;
                    t_op    = req_op[6*m_g +: 6];
                    t_wide  = req_wide[m_g];
                    t_a     = req_a[64*m_g +: 64];
                    t_b     = req_b[64*m_g +: 64];
                    t_exp   = model_rsp(t_op, t_wide, t_a, t_b);
                    t_lat   = (t_exp[67] || (!t_wide && t_op == 6'h2C)) ? 1 : (t_wide ? 3 : 2);
                    gnt_log[acc_cnt] = m_g;
                    acc_cnt++;
                    m_rr = (m_g + 1) % NREQ;
                end
            end else begin
                m_d = cyc - acc_cyc;
                chk("busy_req_ready", 64'(req_ready), 64'd0);
                if (rsp_valid && !seen) begin
                    seen = 1'b1;
                    last_lat = m_d;
                end
                if (m_d < t_lat) begin
                    chk("early_rsp_valid", 64'(rsp_valid), 64'd0);
                    if (m_d == 1) begin
                        chk("lo_alu_ctl", 64'(alu_ctl), 64'(ctl_of(t_op)));
                        chk("lo_alu_ab", {alu_a, alu_b}, {t_a[31:0], t_b[31:0]});
                        chk("lo_alu_cin", 64'(alu_cin), 64'd0);
                    end else begin
                        chk("hi_alu_ctl", 64'(alu_ctl), 64'h2);
                        chk("hi_alu_ab", {alu_a, alu_b}, {t_a[63:32], t_b[63:32]});
                        chk("hi_alu_cin", 64'(alu_cin), 64'(({1'b0, t_a[31:0]} + {1'b0, t_b[31:0]}) >> 32));
                        last_hi_cin = alu_cin;
                    end
                end else begin
                    chk("rsp_valid", 64'(rsp_valid), 64'd1);
                    chk("rsp_id", 64'(rsp_id), 64'(t_id));
                    chk("rsp_res", rsp_res, t_exp[63:0]);
                    chk("rsp_flags", 64'({rsp_err, rsp_cout, rsp_ovf, rsp_zero}), 64'(t_exp[67:64]));
                    chk("resp_alu_ctl", 64'(alu_ctl), 64'(NOOP));
                    if (rsp_ready) begin
                        busy       = 1'b0;
                        last_res   = rsp_res;
                        last_flags = {rsp_err, rsp_cout, rsp_ovf, rsp_zero};
                        last_id    = int'(rsp_id);
                        last_hold  = m_d - t_lat;
                        rsp_cnt++;
                    end
                end
            end
        end
    end

    task automatic set_req(input int i, input logic [5:0] op, input logic w,
                           input logic [63:0] a, input logic [63:0] b);
        req_valid[i]       = 1'b1;
        req_op[6*i +: 6]   = op;
        req_wide[i]        = w;
        req_a[64*i +: 64]  = a;
        req_b[64*i +: 64]  = b;
    endtask

    task automatic wait_acc(input int n);
        int t;
        t = 0;
        while (acc_cnt < n && t < 40) begin @(posedge clk); #1; t++; end
        if (acc_cnt < n) begin
            n_cmp++; n_mis++;
            $display("FAIL accept_timeout: got %0d accepts, required %0d", acc_cnt, n);
        end
    endtask

    task automatic wait_rsp(input int n);
        int t;
        t = 0;
        while (rsp_cnt < n && t < 40) begin @(posedge clk); #1; t++; end
        if (rsp_cnt < n) begin
            n_cmp++; n_mis++;
            $display("FAIL response_timeout: got %0d responses, required %0d", rsp_cnt, n);
        end
    endtask

    task automatic run_one(input int i, input logic [5:0] op, input logic w,
                           input logic [63:0] a, input logic [63:0] b);
        int n0, r0;
        n0 = acc_cnt;
        r0 = rsp_cnt;
        set_req(i, op, w, a, b);
        wait_acc(n0 + 1);
        req_valid = '0;
        wait_rsp(r0 + 1);
    endtask

    typedef struct { logic [5:0] op; logic [63:0] a; logic [63:0] b; logic [63:0] res; int lat; } vec_t;
    vec_t vecs [0:6];
    int   n0, r0;

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{6'h24, 64'hDEAD_BEEF_F0F0_00FF, 64'h0FF0_0F0F, 64'h00F0_000F, 2};
        vecs[1] = '{6'h25, 64'hF0F0_00FF, 64'h0FF0_0F0F, 64'hFFF0_0FFF, 2};
        vecs[2] = '{6'h26, 64'hF0F0_00FF, 64'h0FF0_0F0F, 64'hFF00_0FF0, 2};
        vecs[3] = '{6'h27, 64'd0, 64'd0, 64'hFFFF_FFFF, 2};
        vecs[4] = '{6'h2A, 64'hFFFF_FFFF, 64'd1, 64'd1, 2};
        vecs[5] = '{6'h22, 64'd5, 64'd7, 64'hFFFF_FFFE, 2};
        vecs[6] = '{6'h2C, 64'd9, 64'd9, 64'd0, 1};

        req_valid = '0; req_op = '0; req_wide = '0; req_a = '0; req_b = '0;
        rsp_ready = 1'b0; rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        rsp_ready = 1'b1;

        // Narrow ADD 7+5
        run_one(0, 6'h20, 1'b0, 64'd7, 64'd5);
        chk("t2_res", last_res, 64'd12);
        chk("t2_id", 64'(last_id), 64'd0);
        chk("t2_flags", 64'(last_flags), 64'd0);
        chk("t2_latency", 64'(last_lat), 64'd2);

        // Reset while in EXEC_LO abandons the request
        r0 = rsp_cnt;
        n0 = acc_cnt;
        set_req(0, 6'h20, 1'b0, 64'd1, 64'd2);
        wait_acc(n0 + 1);
        req_valid = '0;
        rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (4) @(posedge clk); #1;
        chk("t1_no_response", 64'(rsp_cnt), 64'(r0));
        chk("t1_rsp_valid", 64'(rsp_valid), 64'd0);

        // Both requesters hammer SUB 3-3: grants alternate from 0
        n0 = acc_cnt;
        r0 = rsp_cnt;
        set_req(0, 6'h22, 1'b0, 64'd3, 64'd3);
        set_req(1, 6'h22, 1'b0, 64'd3, 64'd3);
        wait_acc(n0 + 4);
        req_valid = '0;
        wait_rsp(r0 + 4);
        chk("t3_gnt0", 64'(gnt_log[n0]),     64'd0);
        chk("t3_gnt1", 64'(gnt_log[n0 + 1]), 64'd1);
        chk("t3_gnt2", 64'(gnt_log[n0 + 2]), 64'd0);
        chk("t3_gnt3", 64'(gnt_log[n0 + 3]), 64'd1);
        chk("t3_res", last_res, 64'd0);
        chk("t3_zero", 64'(last_flags[0]), 64'd1);

        // Wide ADD with carry across the 32-bit boundary
        run_one(0, 6'h20, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1);
        chk("t4_res", last_res, 64'h0000_0001_0000_0000);
        chk("t4_flags", 64'(last_flags), 64'd0);
        chk("t4_latency", 64'(last_lat), 64'd3);
        chk("t4_hi_cin", 64'(last_hi_cin), 64'd1);

        // Illegal funct and illegal wide op
        run_one(1, 6'h3F, 1'b0, 64'd5, 64'd6);
        chk("t5a_res", last_res, 64'd0);
        chk("t5a_flags", 64'(last_flags), 64'b1001);
        chk("t5a_latency", 64'(last_lat), 64'd1);
        chk("t5a_id", 64'(last_id), 64'd1);
        run_one(0, 6'h24, 1'b1, 64'hFFFF_0000_FFFF_0000, 64'hFFFF);
        chk("t5b_flags", 64'(last_flags), 64'b1001);
        chk("t5b_latency", 64'(last_lat), 64'd1);

        // Remaining decode table
        for (int v = 0; v < 7; v++) begin
            run_one(v % 2, vecs[v].op, 1'b0, vecs[v].a, vecs[v].b);
            chk($sformatf("vec%0d_res", v), last_res, vecs[v].res);
            chk($sformatf("vec%0d_latency", v), 64'(last_lat), 64'(vecs[v].lat));
        end

        // Overflowing ADD held under back-pressure; requester 1 waits for the handshake
        rsp_ready = 1'b0;
        n0 = acc_cnt;
        r0 = rsp_cnt;
        set_req(0, 6'h20, 1'b0, 64'h7FFF_FFFF, 64'd1);
        wait_acc(n0 + 1);
        req_valid = '0;
        set_req(1, 6'h25, 1'b0, 64'h00F0, 64'h0F00);
        repeat (7) @(posedge clk); #1;
        chk("t6_no_accept", 64'(acc_cnt), 64'(n0 + 1));
        chk("t6_held_valid", 64'(rsp_valid), 64'd1);
        rsp_ready = 1'b1;
        wait_rsp(r0 + 1);
        chk("t6_res", last_res, 64'h8000_0000);
        chk("t6_flags", 64'(last_flags), 64'b0010);
        chk("t6_hold_ge5", 64'(last_hold >= 5), 64'd1);
        wait_acc(n0 + 2);
        req_valid = '0;
        wait_rsp(r0 + 2);
        chk("t6_next_res", last_res, 64'h0FF0);
        chk("t6_next_id", 64'(last_id), 64'd1);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
